// File: rtl/serial_link_calib_pkg.sv
// Shared FSM state and tap-window types for the serial link delay calibrator.
// Window fields are sized for the largest supported tap count; window values never exceed NumSteps.
package serial_link_calib_pkg;

    localparam int CalibMaxSteps = 256;
    localparam int WinW          = $clog2(CalibMaxSteps) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_EVAL,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [WinW-1:0] start;
        logic [WinW-1:0] len;
    } window_t;

    function automatic logic [WinW-1:0] win_center(window_t w);
        return w.start + (w.len >> 1);
    endfunction

endpackage

// File: rtl/serial_link_delay_calib_if.sv
// Valid/ready word stream used for both the PHY side and the user side of the calibrator.
interface serial_link_delay_calib_if #(
    parameter int W = 16
) ();
    logic [W-1:0] dat;
    logic         vld;
    logic         rdy;

    modport master (output dat, output vld, input rdy);
    modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/serial_link_calib_checker.sv
// Per-tap RX pattern checker: first word is the reference, then each word must be previous+1.
// done_o/pass_o are combinational in the final CHECK cycle; all state clears while en_i is low.
module serial_link_calib_checker #(
    parameter int W             = 16,
    parameter int PatternWords  = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         rx_vld_i,
    input  logic [W-1:0] rx_dat_i,
    output logic         done_o,
    output logic         pass_o
);

    localparam int CW = $clog2(PatternWords + 1);
    localparam int TW = $clog2(TimeoutCycles);

    logic          ref_vld_q, ref_vld_d;
    logic [W-1:0]  prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mism_q, mism_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          take, cmp;

    always_comb begin
        take      = en_i && rx_vld_i;
        cmp       = take && ref_vld_q;
        ref_vld_d = ref_vld_q | take;
        prev_d    = take ? rx_dat_i : prev_q;
        cnt_d     = cnt_q + CW'(cmp);
        mism_d    = mism_q | (cmp && (rx_dat_i != prev_q + W'(1)));
        tmo_d     = tmo_q + TW'(1);
        done_o    = en_i && ((cnt_d == CW'(PatternWords)) || (tmo_q == TW'(TimeoutCycles - 1)));
        pass_o    = (cnt_d == CW'(PatternWords)) && !mism_d;
        if (!en_i) begin
            ref_vld_d = 1'b0;
            prev_d    = '0;
            cnt_d     = '0;
            mism_d    = 1'b0;
            tmo_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ref_vld_q <= 1'b0;
            prev_q    <= '0;
            cnt_q     <= '0;
            mism_q    <= 1'b0;
            tmo_q     <= '0;
        end else begin
            ref_vld_q <= ref_vld_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            mism_q    <= mism_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

// File: rtl/serial_link_delay_calib.sv
// Sweeps PHY delay taps with a counter pattern and parks on the centre of the widest passing window.
// Idle/done: zero-latency usr<->phy passthrough; busy: user stalled, RX drained. Bitmap: SERIAL_LINK_CALIB_STATUS_EN.
module serial_link_delay_calib
    import serial_link_calib_pkg::*;
#(
    parameter int  NumLanes      = 8,
    parameter int  NumSteps      = 16,
    parameter int  SettleCycles  = 8,
    parameter int  PatternWords  = 32,
    parameter int  TimeoutCycles = 256,
    parameter int  DefaultDelay  = NumSteps / 2,
    localparam int W             = 2 * NumLanes,
    localparam int DW            = $clog2(NumSteps)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fail_o,
    output logic [DW-1:0]             delay_o,
    output logic [NumSteps-1:0]       pass_map_o,
    serial_link_delay_calib_if.slave  usr_tx,
    serial_link_delay_calib_if.master usr_rx,
    serial_link_delay_calib_if.master phy_tx,
    serial_link_delay_calib_if.slave  phy_rx
);

    localparam int SCW = $clog2(SettleCycles + 1);

    state_e         state_q, state_d;
    logic [DW-1:0]  step_q, step_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic [W-1:0]   k_q, k_d;
    window_t        run_q, run_d, best_q, best_d, run_nxt, cand;
    logic           pass_q, pass_d;
    logic           busy, start_acc, last_step, chk_en, chk_done, chk_pass;

    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK) || (state_q == ST_EVAL);
    assign start_acc = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_step = (step_q == DW'(NumSteps - 1));
    assign chk_en    = (state_q == ST_CHECK);

    serial_link_calib_checker #(
        .W             (W),
        .PatternWords  (PatternWords),
        .TimeoutCycles (TimeoutCycles)
    ) u_checker (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (chk_en),
        .rx_vld_i (phy_rx.vld),
        .rx_dat_i (phy_rx.dat),
        .done_o   (chk_done),
        .pass_o   (chk_pass)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            settle_q <= '0;
            k_q      <= '0;
            run_q    <= '0;
            best_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            settle_q <= settle_d;
            k_q      <= k_d;
            run_q    <= run_d;
            best_q   <= best_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        settle_d = settle_q;
        k_d      = k_q;
        run_d    = run_q;
        best_d   = best_q;
        pass_d   = pass_q;
        run_nxt  = '0;
        cand     = '0;
        if (busy && phy_tx.rdy) begin
            k_d = k_q + W'(1);
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_d  = ST_SETTLE;
                    step_d   = '0;
                    settle_d = '0;
                    run_d    = '0;
                    best_d   = '0;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q + SCW'(1);
                if (settle_q == SCW'(SettleCycles - 1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (chk_done) begin
                    pass_d  = chk_pass;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (pass_q) begin
                    if (run_q.len == '0) begin
                        run_nxt.start = WinW'(step_q);
                        run_nxt.len   = WinW'(1);
                    end else begin
                        run_nxt.start = run_q.start;
                        run_nxt.len   = run_q.len + WinW'(1);
                    end
                end
                cand  = pass_q ? run_nxt : run_q;
                run_d = run_nxt;
                // Strict compare keeps the earliest window when lengths tie.
                if ((!pass_q || last_step) && (cand.len > best_q.len)) begin
                    best_d = cand;
                end
                if (last_step) begin
                    state_d = ST_DONE;
                end else begin
                    step_d   = step_q + DW'(1);
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = busy;
        done_o  = (state_q == ST_DONE);
        fail_o  = (state_q == ST_DONE) && (best_q.len == '0);
        delay_o = DW'(DefaultDelay);
        if (busy) begin
            delay_o = step_q;
        end else if ((state_q == ST_DONE) && (best_q.len != '0)) begin
            delay_o = DW'(win_center(best_q));
        end
        phy_tx.dat = usr_tx.dat;
        phy_tx.vld = usr_tx.vld;
        usr_tx.rdy = phy_tx.rdy;
        usr_rx.dat = phy_rx.dat;
        usr_rx.vld = phy_rx.vld;
        phy_rx.rdy = usr_rx.rdy;
        if (busy) begin
            phy_tx.dat = k_q;
            phy_tx.vld = 1'b1;
            usr_tx.rdy = 1'b0;
            usr_rx.vld = 1'b0;
            phy_rx.rdy = 1'b1;
        end
    end

`ifdef SERIAL_LINK_CALIB_STATUS_EN
    logic [NumSteps-1:0] pass_map_q, pass_map_d;

    always_comb begin
        pass_map_d = pass_map_q;
        if (start_acc) begin
            pass_map_d = '0;
        end else if (state_q == ST_EVAL) begin
            pass_map_d[step_q] = pass_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pass_map_q <= '0;
        end else begin
            pass_map_q <= pass_map_d;
        end
    end

    assign pass_map_o = pass_map_q;
`else
    assign pass_map_o = '0;
`endif

endmodule

// File: tb/tb_serial_link_delay_calib.sv
// Bench: loopback PHY model with per-tap corruption, scoreboard of calibration results, passthrough and reset checks.
module tb_serial_link_delay_calib;

    localparam int         NS      = 16;
    localparam int         W       = 16;
    localparam logic [3:0] DEF_DLY = 4'd8;

    typedef struct {
        logic [3:0]    delay;
        logic          fail;
        logic [NS-1:0] map;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [3:0]    delay;
    logic [NS-1:0] pass_map;

    serial_link_delay_calib_if #(.W(W)) usr_tx ();
    serial_link_delay_calib_if #(.W(W)) usr_rx ();
    serial_link_delay_calib_if #(.W(W)) phy_tx ();
    serial_link_delay_calib_if #(.W(W)) phy_rx ();

    serial_link_delay_calib dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .fail_o     (fail),
        .delay_o    (delay),
        .pass_map_o (pass_map),
        .usr_tx     (usr_tx),
        .usr_rx     (usr_rx),
        .phy_tx     (phy_tx),
        .phy_rx     (phy_rx)
    );

    always #5 clk = ~clk;

    int            n_chk        = 0;
    int            n_fail       = 0;
    int            results_seen = 0;
    exp_t          exp_q[$];
    logic [W-1:0]  lq[$];
    logic [NS-1:0] good_map  = '1;
    bit            stall4    = 1'b0;
    bit            model_en  = 1'b0;
    bit            pt_tx_rdy = 1'b0;
    bit            pt_rx_vld = 1'b0;
    logic [W-1:0]  pt_rx_dat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    // Reference: among all fully-passing windows, the longest wins, earliest start breaks ties.
    function automatic exp_t ref_model(input logic [NS-1:0] good, input bit stall);
        exp_t          r;
        logic [NS-1:0] eff;
        bit            found;
        bit            ok;
        found   = 1'b0;
        eff     = good;
        if (stall) eff[4] = 1'b0;
        r.delay = DEF_DLY;
        r.fail  = 1'b1;
        for (int len = NS; len >= 1; len--) begin
            for (int s = 0; s + len <= NS; s++) begin
                ok = 1'b1;
                for (int t = s; t < s + len; t++) begin
                    if (!eff[t]) ok = 1'b0;
                end
                if (ok && !found) begin
                    found   = 1'b1;
                    r.delay = 4'(s + len / 2);
                    r.fail  = 1'b0;
                end
            end
        end
`ifdef SERIAL_LINK_CALIB_STATUS_EN
        r.map = eff;
`else
        r.map = '0;
`endif
        return r;
    endfunction

    // PHY loopback: TX handshakes enter a FIFO, RX replays them; bad taps scramble each word.
    initial begin
        phy_tx.rdy = 1'b0;
        phy_rx.vld = 1'b0;
        phy_rx.dat = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) lq.delete();
            if (model_en) begin
                phy_tx.rdy = ($urandom_range(0, 9) < 7);
                if (lq.size() > 0 && $urandom_range(0, 9) < 9 && !(stall4 && busy && delay == 4'd4)) begin
                    phy_rx.vld = 1'b1;
                    phy_rx.dat = (good_map[delay] || !busy) ? lq[0] : (lq[0] ^ W'($urandom_range(1, 65535)));
                end else begin
                    phy_rx.vld = 1'b0;
                    phy_rx.dat = W'($urandom);
                end
            end else begin
                phy_tx.rdy = pt_tx_rdy;
                phy_rx.vld = pt_rx_vld;
                phy_rx.dat = pt_rx_dat;
            end
            #4;
            if (model_en && rst_n) begin
                if (phy_tx.vld && phy_tx.rdy) lq.push_back(phy_tx.dat);
                if (phy_rx.vld && phy_rx.rdy && lq.size() > 0) void'(lq.pop_front());
            end
        end
    end

    // Monitor: tap ordering, busy-mode port behaviour, stalled-tap duration, result scoreboard.
    initial begin
        bit   prev_busy;
        bit   prev_done;
        int   last_d;
        int   cnt4;
        exp_t e;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        last_d    = 0;
        cnt4      = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_q.delete();
                prev_busy = 1'b0;
                prev_done = 1'b0;
                cnt4      = 0;
                continue;
            end
            if (busy) begin
                if (!prev_busy) begin
                    check("sweep_first_tap", delay, 0);
                    last_d = delay;
                    cnt4   = 0;
                end else if (delay != last_d) begin
                    check("tap_order", delay, last_d + 1);
                    check("busy_usr_tx_rdy", usr_tx.rdy, 0);
                    check("busy_usr_rx_vld", usr_rx.vld, 0);
                    check("busy_phy_rx_rdy", phy_rx.rdy, 1);
                    check("busy_phy_tx_vld", phy_tx.vld, 1);
                    if (last_d == 4 && stall4) check("tap4_timeout_cycles", cnt4, 8 + 256 + 1);
                    last_d = delay;
                end
                if (delay == 4'd4) cnt4++;
            end
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done with empty scoreboard, required pending result");
                end else begin
                    e = exp_q.pop_front();
                    check("res_delay", delay, e.delay);
                    check("res_fail", fail, e.fail);
                    check("res_pass_map", pass_map, e.map);
                    check("res_busy", busy, 0);
                end
                results_seen++;
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_cal(input logic [NS-1:0] good, input bit st, input bit poke);
        int target;
        good_map = good;
        stall4   = st;
        exp_q.push_back(ref_model(good, st));
        target = results_seen + 1;
        pulse_start();
        if (poke) begin
            for (int i = 0; i < 2000 && delay != 4'd3; i++) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check("start_ignored_tap", delay, 3);
            check("start_ignored_busy", busy, 1);
        end
        for (int i = 0; i < 6000 && results_seen < target; i++) @(negedge clk);
        check("cal_done_within_budget", results_seen, target);
        repeat (3) @(negedge clk);
        #2;
        check("done_sticky", done, 1);
    endtask

    initial begin
        usr_tx.dat = '0;
        usr_tx.vld = 1'b0;
        usr_rx.rdy = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_delay", delay, DEF_DLY);
        check("rst_pass_map", pass_map, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] txw;
            logic         txv, tr, urr;
            @(negedge clk);
            txw        = (i == 0) ? 16'hA5C3 : W'($urandom);
            txv        = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tr         = 1'($urandom_range(0, 1));
            urr        = 1'($urandom_range(0, 1));
            usr_tx.dat = txw;
            usr_tx.vld = txv;
            usr_rx.rdy = urr;
            pt_tx_rdy  = tr;
            pt_rx_dat  = W'($urandom);
            pt_rx_vld  = 1'($urandom_range(0, 1));
            #1;
            check("pt_phy_tx_dat", phy_tx.dat, txw);
            check("pt_phy_tx_vld", phy_tx.vld, txv);
            check("pt_phy_rx_rdy", phy_rx.rdy, urr);
            @(negedge clk);
            #2;
            check("pt_usr_tx_rdy", usr_tx.rdy, tr);
            check("pt_usr_rx_dat", usr_rx.dat, pt_rx_dat);
            check("pt_usr_rx_vld", usr_rx.vld, pt_rx_vld);
        end

        @(negedge clk);
        usr_tx.vld = 1'b0;
        usr_rx.rdy = 1'b1;
        model_en   = 1'b1;

        run_cal(16'h03E0, 1'b0, 1'b0);
        run_cal(16'h0000, 1'b0, 1'b0);
        run_cal(16'h7C0C, 1'b0, 1'b0);
        run_cal(16'h070E, 1'b0, 1'b0);
        run_cal(16'hFFFF, 1'b1, 1'b0);

        good_map = '1;
        stall4   = 1'b0;
        exp_q.push_back(ref_model('1, 1'b0));
        pulse_start();
        for (int i = 0; i < 2000 && !(busy && delay == 4'd6); i++) @(negedge clk);
        repeat (12) @(negedge clk);
        check("abort_at_tap6", delay, 6);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_delay", delay, DEF_DLY);
        check("abort_done", done, 0);
        check("abort_fail", fail, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("post_abort_busy", busy, 0);
        check("post_abort_delay", delay, DEF_DLY);
        run_cal(16'h00F8, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            run_cal(NS'($urandom), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
